// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the fetch stage
package cpu_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational redirect target computation and JR misalign detect
module npc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        sel_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [31:0]       imm_i,
  input  logic [25:0]       t26_i,
  input  logic [ADDR_W-1:0] reg_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] jmp_pc;

  assign seq_pc  = base_i + ADDR_W'(4);
  assign imm_ext = ADDR_W'($signed(imm_i));

  // J keeps the upper region bits of base+4 above the 28-bit jump window
  generate
    if (ADDR_W > 28) begin : g_region
      assign jmp_pc = {seq_pc[ADDR_W-1:28], t26_i, 2'b00};
    end else begin : g_flat
      assign jmp_pc = {t26_i, 2'b00};
    end
  endgenerate

  always_comb begin
    target_o   = seq_pc;
    misalign_o = 1'b0;
    case (npc_sel_e'(sel_i))
      NPC_SEQ: target_o = seq_pc;
      NPC_BR:  target_o = seq_pc + (imm_ext << 2);
      NPC_J:   target_o = jmp_pc;
      NPC_JR: begin
        target_o   = {reg_i[ADDR_W-1:2], 2'b00};
        misalign_o = |reg_i[1:0];
      end
      default: target_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, req/ack instruction fetch and one-entry decode buffer
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [31:0]       redirect_imm,
  input  logic [25:0]       redirect_t26,
  input  logic [ADDR_W-1:0] redirect_reg,
  output logic              fetch_misalign
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              drop_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] target;
  logic              tgt_misalign;

  npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
    .sel_i      (redirect_sel),
    .base_i     (redirect_base),
    .imm_i      (redirect_imm),
    .t26_i      (redirect_t26),
    .reg_i      (redirect_reg),
    .target_o   (target),
    .misalign_o (tgt_misalign)
  );

  // addr_q is separate from pc_q so an in-flight request keeps its address after a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= NOP_WORD;
      instr_pc_q <= '0;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_valid && tgt_misalign;
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          if (redirect_valid) begin
            pc_q   <= target;
            addr_q <= target;
          end else begin
            addr_q <= pc_q;
          end
        end
        ST_REQ: begin
          if (redirect_valid) begin
            pc_q <= target;
            if (imem_ack) begin
              addr_q <= target;
              drop_q <= 1'b0;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_ack) begin
            if (drop_q) begin
              drop_q <= 1'b0;
              addr_q <= pc_q;
            end else begin
              instr_q    <= imem_rdata;
              instr_pc_q <= pc_q;
              pc_q       <= pc_q + ADDR_W'(4);
              state_q    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc_q    <= target;
            addr_q  <= target;
            state_q <= ST_REQ;
          end else if (instr_ready) begin
            addr_q  <= pc_q;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req       = (state_q == ST_REQ);
  assign imem_addr      = addr_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = (state_q == ST_HOLD) && !redirect_valid;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic [25:0] redirect_t26;
  logic [31:0] redirect_reg;
  logic        fetch_misalign;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .redirect_base  (redirect_base),
    .redirect_imm   (redirect_imm),
    .redirect_t26   (redirect_t26),
    .redirect_reg   (redirect_reg),
    .fetch_misalign (fetch_misalign)
  );

  // memory model: ack once the request has been up for lat earlier cycles
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_pc"}, 64'(instr_pc), 64'(exp_pc));
    check({tag, "_instr"}, 64'(instr), 64'(exp_pc ^ KEY));
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] base, input logic [31:0] imm,
                          input logic [25:0] t26, input logic [31:0] rg);
    redirect_valid = 1'b1;
    redirect_sel   = sel;
    redirect_base  = base;
    redirect_imm   = imm;
    redirect_t26   = t26;
    redirect_reg   = rg;
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_sel = 2'b00;
    redirect_base = '0;
    redirect_imm = '0;
    redirect_t26 = '0;
    redirect_reg = '0;
    lat = 0;

    // 1: reset then sequential fetch with zero-wait memory
    repeat (3) next_cycle();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_misalign", 64'(fetch_misalign), 64'd0);
    rst = 1'b0;
    next_cycle();
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", 64'(imem_addr), 64'd0);
    for (int k = 0; k < 4; k++) begin
      wait_valid("seq", 32'(4 * k));
    end

    // 2: stalled decode, slow memory
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      check("stall_req", 64'(imem_req), 64'd0);
      check("stall_valid", 64'(instr_valid), 64'd1);
      check("stall_pc", 64'(instr_pc), 64'h0C);
      check("stall_instr", 64'(instr), 64'(32'h0C ^ KEY));
    end
    lat = 3;
    instr_ready = 1'b1;
    wait_valid("slow", 32'h10);

    // 3: branch redirect from HOLD
    lat = 0;
    redirect(2'b01, 32'h10, 32'hFFFF_FFFE, 26'h0, 32'h0);
    #1;
    check("br_flush_valid", 64'(instr_valid), 64'd0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("br_req", 64'(imem_req), 64'd1);
    check("br_addr", 64'(imem_addr), 64'h0C);
    wait_valid("br", 32'h0C);

    // 4: jump, then misaligned jump-register
    redirect(2'b10, 32'h1000_0040, 32'h0, 26'h000_0100, 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("j_addr", 64'(imem_addr), 64'h1000_0400);
    check("j_misalign", 64'(fetch_misalign), 64'd0);
    wait_valid("j", 32'h1000_0400);
    redirect(2'b11, 32'h0, 32'h0, 26'h0, 32'h0000_1002);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("jr_addr", 64'(imem_addr), 64'h1000);
    check("jr_misalign", 64'(fetch_misalign), 64'd1);
    next_cycle();
    check("jr_misalign_pulse", 64'(fetch_misalign), 64'd0);
    check("jr_valid", 64'(instr_valid), 64'd1);
    check("jr_pc", 64'(instr_pc), 64'h1000);

    // 5: redirect while a request is outstanding
    lat = 2;
    next_cycle();
    redirect(2'b11, 32'h0, 32'h0, 26'h0, 32'h0000_2000);
    #1;
    check("mid_addr0", 64'(imem_addr), 64'h1004);
    check("mid_ack0", 64'(imem_ack), 64'd0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("mid_addr1", 64'(imem_addr), 64'h1004);
    check("mid_req1", 64'(imem_req), 64'd1);
    check("mid_valid1", 64'(instr_valid), 64'd0);
    next_cycle();
    check("mid_addr2", 64'(imem_addr), 64'h1004);
    check("mid_ack2", 64'(imem_ack), 64'd1);
    next_cycle();
    check("mid_retarget", 64'(imem_addr), 64'h2000);
    check("mid_req3", 64'(imem_req), 64'd1);
    check("mid_valid3", 64'(instr_valid), 64'd0);
    lat = 0;
    wait_valid("mid", 32'h2000);

    // redirect (SEQ) in the same cycle as the ack
    next_cycle();
    redirect(2'b00, 32'h3000, 32'h0, 26'h0, 32'h0);
    #1;
    check("same_ack", 64'(imem_ack), 64'd1);
    check("same_valid", 64'(instr_valid), 64'd0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("same_addr", 64'(imem_addr), 64'h3004);
    next_cycle();
    check("same_valid_next", 64'(instr_valid), 64'd1);
    check("same_pc", 64'(instr_pc), 64'h3004);

    // 6: reset while a request is up
    lat = 3;
    next_cycle();
    check("rst2_req_before", 64'(imem_req), 64'd1);
    rst = 1'b1;
    next_cycle();
    check("rst2_req", 64'(imem_req), 64'd0);
    check("rst2_valid", 64'(instr_valid), 64'd0);
    check("rst2_instr", 64'(instr), 64'd0);
    check("rst2_pc", 64'(instr_pc), 64'd0);
    check("rst2_misalign", 64'(fetch_misalign), 64'd0);
    rst = 1'b0;
    lat = 0;
    next_cycle();
    check("rst2_refetch_addr", 64'(imem_addr), 64'd0);
    check("rst2_refetch_req", 64'(imem_req), 64'd1);
    wait_valid("rst2", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
